// File: rtl/matrix_operand_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : matrix_operand_responder                                      |
// | Operand/result responder for a sequential matrix multiplier: holds A/B |
// | loaded from a host stream, captures results into C, then streams C.    |
// | Optional: MATRIX_RESP_COUNT_CHECK_EN adds the err capture-count flag.  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module matrix_operand_responder #(
    parameter int M  = 4,
    parameter int DW = 32,
    localparam int IW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          mul_start,
    input  logic          mul_done,
    input  logic [IW-1:0] a_i,
    input  logic [IW-1:0] a_j,
    output logic [DW-1:0] a_in,
    input  logic [IW-1:0] b_i,
    input  logic [IW-1:0] b_j,
    output logic [DW-1:0] b_in,
    input  logic [DW-1:0] z_out,
    input  logic [IW-1:0] z_i,
    input  logic [IW-1:0] z_j,
    input  logic          z_stb,
    output logic          z_ack,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy
`ifdef MATRIX_RESP_COUNT_CHECK_EN
    ,
    output logic          err
`endif
);

    localparam int            CW     = $clog2(M*M*M+1);
    localparam logic [IW:0]   C_M    = (IW+1)'(M);
    localparam logic [IW-1:0] C_LAST = IW'(M-1);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic          r_ld_ready;
    logic          r_mul_start;
    logic          r_z_ack;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_busy;
    logic [CW-1:0] r_cap;

    logic [DW-1:0] r_a [M][M];
    logic [DW-1:0] r_b [M][M];
    logic [DW-1:0] r_c [M][M];

    logic          w_a_ok;
    logic          w_b_ok;
    logic          w_z_ok;
    logic          w_ld_fire;
    logic          w_z_fire;
    logic          w_rd_fire;
    logic          w_last;
    logic [IW-1:0] w_row_nxt;
    logic [IW-1:0] w_col_nxt;
    logic [CW-1:0] w_cap_nxt;
    logic [DW-1:0] w_c00;

    assign w_a_ok    = ({1'b0, a_i} < C_M) && ({1'b0, a_j} < C_M);
    assign w_b_ok    = ({1'b0, b_i} < C_M) && ({1'b0, b_j} < C_M);
    assign w_z_ok    = ({1'b0, z_i} < C_M) && ({1'b0, z_j} < C_M);
    assign a_in      = w_a_ok ? r_a[a_i][a_j] : '0;
    assign b_in      = w_b_ok ? r_b[b_i][b_j] : '0;

    assign w_ld_fire = ld_valid && r_ld_ready && (r_state == S_LOAD_A || r_state == S_LOAD_B);
    assign w_z_fire  = (r_state == S_RUN) && z_stb && !r_z_ack;
    assign w_rd_fire = (r_state == S_DRAIN) && r_rd_valid && rd_ready;
    assign w_last    = (r_row == C_LAST) && (r_col == C_LAST);
    assign w_col_nxt = (r_col == C_LAST) ? '0 : r_col + 1'b1;
    assign w_row_nxt = (r_col == C_LAST) ? r_row + 1'b1 : r_row;
    assign w_cap_nxt = (r_cap == '1) ? r_cap : r_cap + 1'b1;
    // A capture landing on the S_DRAIN entry edge must be visible in the first word
    assign w_c00     = (w_z_fire && w_z_ok && z_i == '0 && z_j == '0) ? z_out : r_c[0][0];

    assign ld_ready  = r_ld_ready;
    assign mul_start = r_mul_start;
    assign z_ack     = r_z_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign busy      = r_busy;

`ifdef MATRIX_RESP_COUNT_CHECK_EN
    localparam logic [CW-1:0] C_FULL = CW'(M*M*M);
    logic          r_err;
    logic [CW-1:0] w_cap_after;
    assign w_cap_after = w_z_fire ? w_cap_nxt : r_cap;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_START) begin
            r_err <= 1'b0;
        end else if (r_state == S_RUN && mul_done) begin
            r_err <= (w_cap_after != C_FULL);
        end
    end
`endif

    // Matrix storage carries no reset; contents are only meaningful after a load
    always_ff @(posedge clk) begin
        if (w_ld_fire && r_state == S_LOAD_A) begin
            r_a[r_row][r_col] <= ld_data;
        end
        if (w_ld_fire && r_state == S_LOAD_B) begin
            r_b[r_row][r_col] <= ld_data;
        end
        if (r_state == S_START) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < M; j++) begin
                    r_c[i][j] <= '0;
                end
            end
        end else if (w_z_fire && w_z_ok) begin
            r_c[z_i][z_j] <= z_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_LOAD_A;
            r_row       <= '0;
            r_col       <= '0;
            r_ld_ready  <= 1'b0;
            r_mul_start <= 1'b0;
            r_z_ack     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_busy      <= 1'b0;
            r_cap       <= '0;
        end else begin
            r_mul_start <= 1'b0;
            r_z_ack     <= 1'b0;
            case (r_state)
                S_LOAD_A: begin
                    r_ld_ready <= 1'b1;
                    if (w_ld_fire) begin
                        r_row <= w_row_nxt;
                        r_col <= w_col_nxt;
                        if (w_last) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    r_ld_ready <= 1'b1;
                    if (w_ld_fire) begin
                        r_row <= w_row_nxt;
                        r_col <= w_col_nxt;
                        if (w_last) begin
                            r_row       <= '0;
                            r_col       <= '0;
                            r_ld_ready  <= 1'b0;
                            r_mul_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_cap   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_z_fire) begin
                        r_z_ack <= 1'b1;
                        r_cap   <= w_cap_nxt;
                    end
                    if (mul_done) begin
                        r_row      <= '0;
                        r_col      <= '0;
                        r_busy     <= 1'b0;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_c00;
                        r_state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_rd_fire) begin
                        if (w_last) begin
                            r_row      <= '0;
                            r_col      <= '0;
                            r_rd_valid <= 1'b0;
                            r_ld_ready <= 1'b1;
                            r_state    <= S_LOAD_A;
                        end else begin
                            r_row     <= w_row_nxt;
                            r_col     <= w_col_nxt;
                            r_rd_data <= r_c[w_row_nxt][w_col_nxt];
                        end
                    end
                end
                default: begin
                    r_state    <= S_LOAD_A;
                    r_ld_ready <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_matrix_operand_responder                                   |
// | Scoreboard bench for matrix_operand_responder (M=2) with random ops.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_matrix_operand_responder;

    localparam int M    = 2;
    localparam int DW   = 32;
    localparam int IW   = 1;
    localparam int NW   = M*M;
    localparam int CMAX = (1 << $clog2(M*M*M+1)) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          mul_start;
    logic          mul_done = 1'b0;
    logic [IW-1:0] a_i = '0, a_j = '0, b_i = '0, b_j = '0;
    logic [DW-1:0] a_in, b_in;
    logic [DW-1:0] z_out = '0;
    logic [IW-1:0] z_i = '0, z_j = '0;
    logic          z_stb = 1'b0;
    logic          z_ack;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
`ifdef MATRIX_RESP_COUNT_CHECK_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    matrix_operand_responder #(.M(M), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .mul_start(mul_start), .mul_done(mul_done),
        .a_i(a_i), .a_j(a_j), .a_in(a_in),
        .b_i(b_i), .b_j(b_j), .b_in(b_in),
        .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy)
`ifdef MATRIX_RESP_COUNT_CHECK_EN
        , .err(err)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ma [NW];
    logic [DW-1:0] mb [NW];
    logic [DW-1:0] mc [NW];
    logic [DW-1:0] ldw [2*NW];
    logic [DW-1:0] sb_q [$];
    int            cap_cnt = 0;
    logic          err_exp = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_err();
        int sat;
        sat = (cap_cnt > CMAX) ? CMAX : cap_cnt;
        return sat != M*M*M;
    endfunction

    // Monitor: pops the expected C word on every accepted readout beat
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic [DW-1:0] mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else if (rd_valid) begin
            if (prev_stall) chk("rd_stable", rd_data, prev_data);
            if (rd_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h expected no word", rd_data);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("rd_data", rd_data, mon_exp);
                end
            end
            prev_stall = !rd_ready;
            prev_data  = rd_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_load(input bit gaps);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < 2*NW && guard < 500) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid = 1'b1;
                ld_data  = ldw[n];
            end
            acc = ld_valid && ld_ready;
            tick();
            guard++;
            if (acc) n++;
        end
        ld_valid = 1'b0;
        chk("load_words", n, 2*NW);
        for (int k = 0; k < NW; k++) begin
            ma[k] = ldw[k];
            mb[k] = ldw[NW+k];
            mc[k] = '0;
        end
        cap_cnt = 0;
        chk("mul_start_hi", mul_start, 1'b1);
        chk("ld_ready_off", ld_ready, 1'b0);
        chk("busy_start", busy, 1'b1);
        tick();
        chk("mul_start_lo", mul_start, 1'b0);
        chk("busy_run", busy, 1'b1);
`ifdef MATRIX_RESP_COUNT_CHECK_EN
        chk("err_cleared", err, 1'b0);
`endif
    endtask

    task automatic check_reads(input int n);
        for (int k = 0; k < n; k++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            a_i = IW'($urandom_range(0, M-1));
            a_j = IW'($urandom_range(0, M-1));
            b_i = IW'($urandom_range(0, M-1));
            b_j = IW'($urandom_range(0, M-1));
            #1;
            chk("a_in", a_in, ma[int'(a_i)*M + int'(a_j)]);
            chk("b_in", b_in, mb[int'(b_i)*M + int'(b_j)]);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic do_capture(input int i, input int j, input logic [DW-1:0] v);
        z_i = IW'(i); z_j = IW'(j); z_out = v; z_stb = 1'b1;
        tick();
        chk("z_ack_hi", z_ack, 1'b1);
        z_stb = 1'b0;
        tick();
        chk("z_ack_lo", z_ack, 1'b0);
        mc[i*M+j] = v;
        cap_cnt++;
    endtask

    task automatic do_held(input int i, input int j, input logic [DW-1:0] v, input int n);
        z_i = IW'(i); z_j = IW'(j); z_out = v; z_stb = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("z_ack_held", z_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        z_stb = 1'b0;
        mc[i*M+j] = v;
        cap_cnt += (n + 1) / 2;
    endtask

    task automatic do_done(input bit simul);
        int i, j;
        logic [DW-1:0] v;
        i = $urandom_range(0, M-1);
        j = $urandom_range(0, M-1);
        v = $urandom;
        if (simul) begin
            z_i = IW'(i); z_j = IW'(j); z_out = v; z_stb = 1'b1;
        end
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        z_stb    = 1'b0;
        if (simul) begin
            chk("z_ack_done", z_ack, 1'b1);
            mc[i*M+j] = v;
            cap_cnt++;
        end
        for (int k = 0; k < NW; k++) sb_q.push_back(mc[k]);
        chk("rd_valid_on", rd_valid, 1'b1);
        chk("busy_drain", busy, 1'b0);
        err_exp = model_err();
`ifdef MATRIX_RESP_COUNT_CHECK_EN
        chk("err", err, err_exp);
`endif
        rd_ready = 1'b0;
        tick();
        chk("z_ack_after_done", z_ack, 1'b0);
    endtask

    task automatic do_drain(input bit pattern);
        int n = 0;
        int k = 0;
        bit acc;
        while (n < NW && k < 200) begin
            rd_ready = pattern ? ((k % 4 == 0) || (k % 4 == 3)) : 1'($urandom_range(0, 1));
            acc = rd_valid && rd_ready;
            tick();
            k++;
            if (acc) n++;
        end
        rd_ready = 1'b0;
        chk("drain_words", n, NW);
        chk("rd_valid_off", rd_valid, 1'b0);
        chk("sb_empty", sb_q.size(), 0);
`ifdef MATRIX_RESP_COUNT_CHECK_EN
        chk("err_sticky", err, err_exp);
`endif
        tick();
        chk("ld_ready_reload", ld_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_z_ack", z_ack, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_busy", busy, 1'b0);
`ifdef MATRIX_RESP_COUNT_CHECK_EN
        chk("rst_err", err, 1'b0);
`endif
        rst = 1'b1;
        #1;
        chk("ld_ready_release", ld_ready, 1'b0);
        tick();
        chk("ld_ready_first", ld_ready, 1'b1);

        // Directed walk through load, reads, captures and a patterned drain
        ldw = '{32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_load(1'b0);
        a_i = 1'b1; a_j = 1'b1; b_i = 1'b1; b_j = 1'b0;
        #1;
        chk("a_in_11", a_in, 32'h3F800000);
        chk("b_in_10", b_in, 32'h40400000);
        check_reads(4);
        do_capture(1, 0, 32'h40400000);
        do_held(0, 1, 32'h11111111, 6);
        do_done(1'b0);
        chk("model_word2", sb_q[2], 32'h40400000);
        do_drain(1'b1);

        // Reset while a capture is being acknowledged
        for (int k = 0; k < 2*NW; k++) ldw[k] = $urandom;
        do_load(1'b1);
        z_i = 1'b0; z_j = 1'b1; z_out = 32'hDEADBEEF; z_stb = 1'b1;
        tick();
        chk("z_ack_pre_rst", z_ack, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_z_ack", z_ack, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ld_ready", ld_ready, 1'b0);
        tick();
        chk("rst_hold_z_ack", z_ack, 1'b0);
        rst = 1'b1;
        z_stb = 1'b0;
        chk("ld_ready_rel2", ld_ready, 1'b0);
        tick();
        chk("ld_ready_rel2_on", ld_ready, 1'b1);

        // Randomised operations
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2*NW; k++) ldw[k] = $urandom;
            do_load(1'b1);
            check_reads(3);
            for (int c = $urandom_range(0, 9); c > 0; c--) begin
                if ($urandom_range(0, 2) == 0)
                    do_held($urandom_range(0, M-1), $urandom_range(0, M-1), $urandom,
                            2 * $urandom_range(1, 3));
                else
                    do_capture($urandom_range(0, M-1), $urandom_range(0, M-1), $urandom);
            end
            do_done(1'($urandom_range(0, 1)));
            do_drain(1'b0);
        end

        // Exactly M^3 captures versus one short
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2*NW; k++) ldw[k] = $urandom;
            do_load(1'b0);
            for (int c = 0; c < M*M*M - 1 + r; c++)
                do_capture(c % M, (c / M) % M, $urandom);
            do_done(1'b0);
            do_drain(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
